// File: rtl/adsr_envelope_shaper.sv
// ADSR amplitude envelope applied to the signed summed sample, stepped by an 8 kHz tick.
// Define ADSR_EXP_RELEASE_EN for an exponential-like release tail instead of a linear one.
module adsr_envelope_shaper #(
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 2,
    parameter int unsigned SUSTAIN_LEVEL = 192,
    parameter int unsigned RELEASE_STEP  = 4,
    parameter int unsigned RELEASE_SHIFT = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       step_in,
    input  logic       gate_in,
    input  logic       sample_valid_in,
    input  logic [7:0] sample_in,
    output logic       sample_valid_out,
    output logic [7:0] sample_out,
    output logic [7:0] env_level_out,
    output logic [2:0] env_state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;
    logic [7:0] r_level, w_level_nxt;
    logic       r_gate_q;
    logic       r_valid;
    logic [7:0] r_sample;

    logic w_rise, w_fall;
    logic [8:0] w_att_sum, w_dec_diff, w_rel_dec, w_rel_diff;
    logic signed [16:0] w_product;
    logic [7:0] w_scaled;

    assign w_rise = gate_in & ~r_gate_q;
    assign w_fall = ~gate_in & r_gate_q;

    // Bit 8 of the differences flags a borrow, i.e. the step overshot zero.
    assign w_att_sum  = {1'b0, r_level} + 9'(ATTACK_STEP);
    assign w_dec_diff = {1'b0, r_level} - 9'(DECAY_STEP);
`ifdef ADSR_EXP_RELEASE_EN
    assign w_rel_dec  = ({1'b0, r_level} >> RELEASE_SHIFT) + 9'd1;
`else
    assign w_rel_dec  = 9'(RELEASE_STEP);
`endif
    assign w_rel_diff = {1'b0, r_level} - w_rel_dec;

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        if (w_rise && (r_state == S_IDLE || r_state == S_RELEASE)) begin
            w_state_nxt = S_ATTACK;
        end else if (w_fall && (r_state == S_ATTACK || r_state == S_DECAY ||
                                r_state == S_SUSTAIN)) begin
            w_state_nxt = S_RELEASE;
        end else if (step_in && !(w_rise || w_fall)) begin
            case (r_state)
                S_IDLE: w_level_nxt = '0;
                S_ATTACK: begin
                    if (w_att_sum >= 9'd255) begin
                        w_level_nxt = '1;
                        w_state_nxt = S_DECAY;
                    end else begin
                        w_level_nxt = w_att_sum[7:0];
                    end
                end
                S_DECAY: begin
                    if (w_dec_diff[8] || (w_dec_diff <= 9'(SUSTAIN_LEVEL))) begin
                        w_level_nxt = 8'(SUSTAIN_LEVEL);
                        w_state_nxt = S_SUSTAIN;
                    end else begin
                        w_level_nxt = w_dec_diff[7:0];
                    end
                end
                S_SUSTAIN: w_level_nxt = r_level;
                S_RELEASE: begin
                    if (w_rel_diff[8] || (w_rel_diff == 9'd0)) begin
                        w_level_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_level_nxt = w_rel_diff[7:0];
                    end
                end
                default: begin
                    w_level_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Level is zero-extended so it acts as an unsigned 0..255 gain.
    assign w_product = $signed(sample_in) * $signed({1'b0, r_level});
    assign w_scaled  = 8'(w_product >>> 8);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_level  <= '0;
            r_gate_q <= 1'b0;
            r_valid  <= 1'b0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_level  <= w_level_nxt;
            r_gate_q <= gate_in;
            r_valid  <= sample_valid_in;
            if (sample_valid_in) begin
                r_sample <= w_scaled;
            end
        end
    end

    assign sample_valid_out = r_valid;
    assign sample_out       = r_sample;
    assign env_level_out    = r_level;
    assign env_state_out    = r_state;

endmodule
